// File: rtl/minroot_job_ctrl.sv
// minroot_job_ctrl: accepts one MinRoot job, drives an external iteration engine and returns its result.
// Optional watchdog on engine progress: define MINROOT_JOB_TIMEOUT_EN.
package mrt_pkg;
    localparam int PolyW = 32;
    localparam int IterW = 16;
    typedef logic [PolyW-1:0] poly_t;
    typedef logic [IterW-1:0] IterBits;
endpackage

module minroot_job_ctrl #(
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  mrt_pkg::poly_t   job_x_i,
    input  mrt_pkg::poly_t   job_y_i,
    input  mrt_pkg::IterBits job_start_iter_i,
    input  mrt_pkg::IterBits job_iters_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output mrt_pkg::poly_t   res_x_o,
    output mrt_pkg::poly_t   res_y_o,
    output mrt_pkg::IterBits res_iter_o,
    output logic [1:0]       res_status_o,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             eng_start_o,
    output mrt_pkg::IterBits eng_starting_iter_o,
    output mrt_pkg::IterBits eng_iters_o,
    output mrt_pkg::poly_t   eng_x_o,
    output mrt_pkg::poly_t   eng_y_o,
    input  mrt_pkg::poly_t   eng_x_i,
    input  mrt_pkg::poly_t   eng_y_i,
    input  mrt_pkg::IterBits eng_cur_iter_i,
    input  logic             eng_iter_done_i
);
    import mrt_pkg::*;

    localparam logic [1:0] StOk      = 2'b00;
    localparam logic [1:0] StAbort   = 2'b01;
    localparam logic [1:0] StTimeout = 2'b10;

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, RESP} state_e;

    state_e     state_q, state_d;
    poly_t      hx_q, hx_d, hy_q, hy_d;
    IterBits    hstart_q, hstart_d, hiters_q, hiters_d;
    poly_t      rx_q, rx_d, ry_q, ry_d;
    IterBits    riter_q, riter_d;
    logic [1:0] rstat_q, rstat_d;
    logic       done_hit, wd_hit;

`ifdef MINROOT_JOB_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        wd_active;

    assign wd_active = (state_q == RUN) || (state_q == DRAIN);
    assign wd_d      = (eng_start_o || eng_iter_done_i) ? '0 : wd_active ? wd_q + 32'd1 : wd_q;
    // Fires one cycle early so RESP appears exactly TimeoutCycles after the last progress event.
    assign wd_hit    = wd_active && !eng_iter_done_i && (wd_q == TimeoutCycles - 32'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`else
    localparam int unsigned unused_timeout_cycles = TimeoutCycles;
    assign wd_hit = 1'b0;
`endif

    assign done_hit            = eng_iter_done_i && (eng_cur_iter_i > hiters_q);
    assign job_ready_o         = rst_ni && (state_q == IDLE);
    assign busy_o              = state_q != IDLE;
    assign eng_start_o         = state_q == LAUNCH;
    assign res_valid_o         = state_q == RESP;
    assign res_x_o             = rx_q;
    assign res_y_o             = ry_q;
    assign res_iter_o          = riter_q;
    assign res_status_o        = rstat_q;
    assign eng_x_o             = hx_q;
    assign eng_y_o             = hy_q;
    assign eng_starting_iter_o = hstart_q;
    assign eng_iters_o         = hiters_q;

    always_comb begin
        state_d  = state_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        hstart_d = hstart_q;
        hiters_d = hiters_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        riter_d  = riter_q;
        rstat_d  = rstat_q;
        case (state_q)
            IDLE: begin
                if (job_valid_i && job_ready_o) begin
                    hx_d     = job_x_i;
                    hy_d     = job_y_i;
                    hstart_d = job_start_iter_i;
                    hiters_d = job_iters_i;
                    if (job_iters_i >= job_start_iter_i) begin
                        state_d = LAUNCH;
                    end else begin
                        rx_d    = job_x_i;
                        ry_d    = job_y_i;
                        riter_d = job_start_iter_i;
                        rstat_d = StOk;
                        state_d = RESP;
                    end
                end
            end
            LAUNCH: begin
                hiters_d = abort_i ? '0 : hiters_q;
                state_d  = abort_i ? DRAIN : RUN;
            end
            RUN: begin
                if (done_hit) begin
                    rx_d    = eng_x_i;
                    ry_d    = eng_y_i;
                    riter_d = eng_cur_iter_i;
                    rstat_d = StOk;
                    state_d = RESP;
                end else if (abort_i) begin
                    hiters_d = '0;
                    state_d  = DRAIN;
                end else if (wd_hit) begin
                    hiters_d = '0;
                    rx_d     = hx_q;
                    ry_d     = hy_q;
                    riter_d  = hstart_q;
                    rstat_d  = StTimeout;
                    state_d  = RESP;
                end
            end
            DRAIN: begin
                if (eng_iter_done_i) begin
                    rx_d    = eng_x_i;
                    ry_d    = eng_y_i;
                    riter_d = eng_cur_iter_i;
                    rstat_d = StAbort;
                    state_d = RESP;
                end else if (wd_hit) begin
                    rx_d    = hx_q;
                    ry_d    = hy_q;
                    riter_d = hstart_q;
                    rstat_d = StTimeout;
                    state_d = RESP;
                end
            end
            RESP:    state_d = res_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            hx_q     <= '0;
            hy_q     <= '0;
            hstart_q <= '0;
            hiters_q <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            riter_q  <= '0;
            rstat_q  <= '0;
        end else begin
            state_q  <= state_d;
            hx_q     <= hx_d;
            hy_q     <= hy_d;
            hstart_q <= hstart_d;
            hiters_q <= hiters_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            riter_q  <= riter_d;
            rstat_q  <= rstat_d;
        end
    end
endmodule

// File: tb/tb_minroot_job_ctrl.sv
// tb_minroot_job_ctrl: scoreboard bench for minroot_job_ctrl with a 10-cycle-per-iteration engine model.
// Set MINROOT_JOB_TIMEOUT_EN to also exercise the watchdog.
module tb_minroot_job_ctrl;
    import mrt_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       job_valid_i, job_ready_o, res_valid_o, res_ready_i, abort_i, busy_o;
    poly_t      job_x_i, job_y_i, res_x_o, res_y_o, eng_x_o, eng_y_o, eng_x_i, eng_y_i;
    IterBits    job_start_iter_i, job_iters_i, res_iter_o, eng_starting_iter_o, eng_iters_o, eng_cur_iter_i;
    logic [1:0] res_status_o;
    logic       eng_start_o, eng_iter_done_i;

    always #5 clk_i = ~clk_i;

    minroot_job_ctrl #(.TimeoutCycles(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_x_i(job_x_i), .job_y_i(job_y_i),
        .job_start_iter_i(job_start_iter_i), .job_iters_i(job_iters_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_x_o(res_x_o), .res_y_o(res_y_o), .res_iter_o(res_iter_o), .res_status_o(res_status_o),
        .abort_i(abort_i), .busy_o(busy_o),
        .eng_start_o(eng_start_o), .eng_starting_iter_o(eng_starting_iter_o), .eng_iters_o(eng_iters_o),
        .eng_x_o(eng_x_o), .eng_y_o(eng_y_o), .eng_x_i(eng_x_i), .eng_y_i(eng_y_i),
        .eng_cur_iter_i(eng_cur_iter_i), .eng_iter_done_i(eng_iter_done_i)
    );

    typedef struct packed {
        poly_t      x;
        poly_t      y;
        IterBits    it;
        logic [1:0] st;
    } res_t;

    res_t    exp_q[$];
    int      total = 0, bad = 0, cyc = 0;
    int      n_res = 0, n_start = 0, n_done = 0, start_cyc = -1, res_cyc = -1;
    logic    eng_hang = 1'b0;
    logic    ebusy = 1'b0;
    int      ecnt = 0;
    poly_t   ex = '0, ey = '0;
    IterBits ecur = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Toy MinRoot-like round used by the engine model; the DUT only forwards its values.
    function automatic void step(inout poly_t x, inout poly_t y, input IterBits i);
        poly_t nx;
        nx = x * 32'd5 + y + poly_t'(i);
        y  = x + poly_t'(i);
        x  = nx;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        eng_iter_done_i = 1'b0;
        eng_x_i = '0;
        eng_y_i = '0;
        eng_cur_iter_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            eng_iter_done_i = 1'b0;
            if (!rst_ni) begin
                ebusy = 1'b0;
            end else if (eng_start_o) begin
                ebusy = 1'b1;
                ecnt  = 0;
                ex    = eng_x_o;
                ey    = eng_y_o;
                ecur  = eng_starting_iter_o;
            end else if (ebusy && !eng_hang) begin
                ecnt++;
                if (ecnt == 10) begin
                    step(ex, ey, ecur);
                    ecur++;
                    ecnt = 0;
                    eng_iter_done_i = 1'b1;
                    n_done++;
                    if (ecur > eng_iters_o) ebusy = 1'b0;
                end
            end
            eng_x_i = ex;
            eng_y_i = ey;
            eng_cur_iter_i = ecur;
        end
    end

    always @(negedge clk_i) begin : mon
        res_t e;
        if (rst_ni && eng_start_o) begin
            n_start++;
            start_cyc = cyc;
        end
        if (rst_ni && res_valid_o && res_ready_i) begin
            n_res++;
            res_cyc = cyc;
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_x", 64'(res_x_o), 64'(e.x));
                check("res_y", 64'(res_y_o), 64'(e.y));
                check("res_iter", 64'(res_iter_o), 64'(e.it));
                check("res_status", 64'(res_status_o), 64'(e.st));
            end
        end
    end

    task automatic send_job(input poly_t x, input poly_t y, input IterBits s, input IterBits it, output int t);
        @(posedge clk_i);
        #1;
        job_valid_i = 1'b1;
        job_x_i = x;
        job_y_i = y;
        job_start_iter_i = s;
        job_iters_i = it;
        t = -1;
        for (int k = 0; k < 100 && t < 0; k++) begin
            @(negedge clk_i);
            if (job_ready_o) t = cyc;
        end
        @(posedge clk_i);
        #1;
        job_valid_i = 1'b0;
        check("job_accepted", 64'(t >= 0), 64'd1);
    endtask

    task automatic wait_res(input int n, input int lim);
        for (int k = 0; k < lim && n_res < n; k++) @(negedge clk_i);
        check("result_arrived", 64'(n_res >= n), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int   t, s0, r0, d0;
        logic stable, rdy_low, seen;
        res_t snap;
        job_valid_i = 1'b0;
        job_x_i = '0;
        job_y_i = '0;
        job_start_iter_i = '0;
        job_iters_i = '0;
        res_ready_i = 1'b1;
        abort_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check("rst_job_ready", 64'(job_ready_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_eng_start", 64'(eng_start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_status", 64'(res_status_o), 64'd0);
        check("rst_res_x", 64'(res_x_o), 64'd0);
        check("rst_res_iter", 64'(res_iter_o), 64'd0);
        check("rst_eng_iters", 64'(eng_iters_o), 64'd0);
        check("rst_eng_x", 64'(eng_x_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rel_job_ready", 64'(job_ready_o), 64'd1);
        check("rel_busy", 64'(busy_o), 64'd0);

        // Normal run: start 0, last 3 -> four iterations.
        exp_q.push_back('{32'd3094, 32'd598, 16'd4, 2'b00});
        s0 = n_start;
        r0 = n_res;
        send_job(32'd3, 32'd7, 16'd0, 16'd3, t);
        wait_res(r0 + 1, 200);
        check("A_start_cycle", 64'(start_cyc), 64'(t + 1));
        check("A_start_count", 64'(n_start - s0), 64'd1);
        repeat (5) @(negedge clk_i);
        check("A_result_count", 64'(n_res - r0), 64'd1);

        // Empty range: result straight from the job fields.
        exp_q.push_back('{32'h1234, 32'hABCD, 16'd5, 2'b00});
        s0 = n_start;
        r0 = n_res;
        send_job(32'h1234, 32'hABCD, 16'd5, 16'd2, t);
        wait_res(r0 + 1, 20);
        check("B_result_cycle", 64'(res_cyc), 64'(t + 1));
        repeat (3) @(negedge clk_i);
        check("B_no_start", 64'(n_start - s0), 64'd0);

        // Abort after the second done.
        exp_q.push_back('{32'd195, 32'd39, 16'd3, 2'b01});
        r0 = n_res;
        d0 = n_done;
        send_job(32'd1, 32'd2, 16'd0, 16'd100, t);
        for (int k = 0; k < 200 && n_done - d0 < 2; k++) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        d0 = n_done;
        @(negedge clk_i);
        check("C_eng_iters_zero", 64'(eng_iters_o), 64'd0);
        check("C_busy", 64'(busy_o), 64'd1);
        wait_res(r0 + 1, 100);
        repeat (40) @(negedge clk_i);
        check("C_one_more_done", 64'(n_done - d0), 64'd1);

        // Back-pressure on the result side.
        res_ready_i = 1'b0;
        exp_q.push_back('{32'd110, 32'd24, 16'd5, 2'b00});
        r0 = n_res;
        send_job(32'd0, 32'd1, 16'd2, 16'd4, t);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_i);
            seen = res_valid_o;
        end
        check("D_valid_seen", 64'(seen), 64'd1);
        snap = '{res_x_o, res_y_o, res_iter_o, res_status_o};
        stable = 1'b1;
        rdy_low = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (!res_valid_o || snap != {res_x_o, res_y_o, res_iter_o, res_status_o}) stable = 1'b0;
            if (job_ready_o) rdy_low = 1'b0;
        end
        check("D_result_stable", 64'(stable), 64'd1);
        check("D_job_ready_low", 64'(rdy_low), 64'd1);
        check("D_no_early_pop", 64'(n_res - r0), 64'd0);
        @(posedge clk_i);
        #1;
        res_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("D_idle_ready", 64'(job_ready_o), 64'd1);
        check("D_idle_busy", 64'(busy_o), 64'd0);
        check("D_result_count", 64'(n_res - r0), 64'd1);

        // Reset mid-run at iteration 7, then a fresh job.
        r0 = n_res;
        send_job(32'd9, 32'd9, 16'd0, 16'd20, t);
        for (int k = 0; k < 200 && ecur != 16'd7; k++) @(negedge clk_i);
        check("E_reached_iter7", 64'(ecur), 64'd7);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("E_rst_busy", 64'(busy_o), 64'd0);
        check("E_rst_job_ready", 64'(job_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("E_rel_job_ready", 64'(job_ready_o), 64'd1);
        check("E_no_result", 64'(n_res - r0), 64'd0);
        exp_q.push_back('{32'd60, 32'd13, 16'd3, 2'b00});
        send_job(32'd2, 32'd0, 16'd1, 16'd2, t);
        wait_res(r0 + 1, 200);

`ifdef MINROOT_JOB_TIMEOUT_EN
        // Engine never reports progress.
        eng_hang = 1'b1;
        exp_q.push_back('{32'd5, 32'd6, 16'd2, 2'b10});
        r0 = n_res;
        send_job(32'd5, 32'd6, 16'd2, 16'd9, t);
        wait_res(r0 + 1, 200);
        check("T_timeout_latency", 64'(res_cyc - start_cyc), 64'd64);
        eng_hang = 1'b0;
`endif

        repeat (5) @(negedge clk_i);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
